// File: rtl/cmd_scheduler.sv
// cmd_scheduler: pops 80-bit commands, holds timed ones until global_clock reaches their start time,
// then dispatches over valid/ready. Optional macro CMD_SCHED_LATE_COUNT_EN adds the late_count output.
module cmd_scheduler #(
  parameter int unsigned NUM_CHANNELS = 64,
  parameter logic [7:0]  OP_IMMEDIATE = 8'hFF,
  parameter logic [7:0]  OP_NOP       = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] cmd_fifo_data_out,
  output logic        cmd_fifo_rd_en,
  input  logic        cmd_fifo_empty,
  input  logic [31:0] global_clock,
  input  logic        flush,
  output logic        ctrl_valid,
  input  logic        ctrl_ready,
  output logic [7:0]  ctrl_channel,
  output logic [7:0]  ctrl_opcode,
  output logic [31:0] ctrl_payload,
  output logic        busy,
  output logic [15:0] drop_count
`ifdef CMD_SCHED_LATE_COUNT_EN
  ,
  output logic [15:0] late_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_LATCH     = 3'd2,
    S_WAIT_TIME = 3'd3,
    S_ISSUE     = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] start_time_r;
  logic        rd_en_s;
  logic        drop_s;
  logic        channel_ok_s;
  logic        time_reached_s;
  logic [7:0]  cmd_channel_s;
  logic [7:0]  cmd_opcode_s;
  logic [31:0] time_diff_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  assign cmd_channel_s  = cmd_fifo_data_out[79:72];
  assign cmd_opcode_s   = cmd_fifo_data_out[71:64];
  assign channel_ok_s   = ({24'd0, cmd_channel_s} < NUM_CHANNELS);
  // Sign of the modular difference keeps the due-time compare correct across counter wrap.
  assign time_diff_s    = global_clock - start_time_r;
  assign time_reached_s = ~time_diff_s[31];
  // The pop strobe is decoded from the current state so the FIFO pops while still in IDLE.
  assign cmd_fifo_rd_en = rd_en_s & ~rst;

  // Next-state decode, pop request and drop event.
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!cmd_fifo_empty && !flush) begin
          rd_en_s      = 1'b1;
          state_next_s = S_POP;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_POP: begin
        if (flush) state_next_s = S_IDLE;
        else       state_next_s = S_LATCH;
      end
      S_LATCH: begin
        if (flush) begin
          state_next_s = S_IDLE;
        end else if (cmd_opcode_s == OP_NOP) begin
          state_next_s = S_IDLE;
        end else if (!channel_ok_s) begin
          drop_s       = 1'b1;
          state_next_s = S_IDLE;
        end else if (cmd_opcode_s == OP_IMMEDIATE) begin
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_WAIT_TIME;
        end
      end
      S_WAIT_TIME: begin
        if (flush)               state_next_s = S_IDLE;
        else if (time_reached_s) state_next_s = S_ISSUE;
        else                     state_next_s = S_WAIT_TIME;
      end
      S_ISSUE: begin
        if (ctrl_ready || flush) state_next_s = S_IDLE;
        else                     state_next_s = S_ISSUE;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register, registered dispatch fields, status and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      start_time_r <= 32'd0;
      ctrl_valid   <= 1'b0;
      ctrl_channel <= 8'd0;
      ctrl_opcode  <= 8'd0;
      ctrl_payload <= 32'd0;
      busy         <= 1'b0;
      drop_count   <= 16'd0;
    end else begin
      state_r    <= state_next_s;
      ctrl_valid <= (state_next_s == S_ISSUE);
      busy       <= (state_next_s != S_IDLE);
      if (state_r == S_LATCH) begin
        ctrl_channel <= cmd_channel_s;
        ctrl_opcode  <= cmd_opcode_s;
        start_time_r <= cmd_fifo_data_out[63:32];
        ctrl_payload <= cmd_fifo_data_out[31:0];
      end
      if (drop_s) begin
        drop_count <= sat_inc16(drop_count);
      end
    end
  end

`ifdef CMD_SCHED_LATE_COUNT_EN
  logic late_check_r;
  logic late_r;

  // Record lateness on the first WAIT_TIME cycle and count it when the dispatch completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      late_check_r <= 1'b0;
      late_r       <= 1'b0;
      late_count   <= 16'd0;
    end else begin
      late_check_r <= (state_r == S_LATCH) && (state_next_s == S_WAIT_TIME);
      if (state_r == S_LATCH) begin
        late_r <= 1'b0;
      end else if (late_check_r && (state_r == S_WAIT_TIME)) begin
        late_r <= time_reached_s;
      end
      if ((state_r == S_ISSUE) && ctrl_ready && late_r) begin
        late_count <= sat_inc16(late_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed self-checking bench for cmd_scheduler: FIFO model, driven time base, per-scenario tasks.
module tb_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] fifo_data;
  logic        rd_en;
  logic        empty;
  logic [31:0] gclk;
  logic        flush;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [7:0]  ctrl_channel;
  logic [7:0]  ctrl_opcode;
  logic [31:0] ctrl_payload;
  logic        busy;
  logic [15:0] drop_count;
`ifdef CMD_SCHED_LATE_COUNT_EN
  logic [15:0] late_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int pop_count = 0;
  int pop_cycs[$];
  logic [79:0] fifo_q[$];

  always #5 clk = ~clk;

  cmd_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_fifo_data_out (fifo_data),
    .cmd_fifo_rd_en    (rd_en),
    .cmd_fifo_empty    (empty),
    .global_clock      (gclk),
    .flush             (flush),
    .ctrl_valid        (ctrl_valid),
    .ctrl_ready        (ctrl_ready),
    .ctrl_channel      (ctrl_channel),
    .ctrl_opcode       (ctrl_opcode),
    .ctrl_payload      (ctrl_payload),
    .busy              (busy),
    .drop_count        (drop_count)
`ifdef CMD_SCHED_LATE_COUNT_EN
    ,
    .late_count        (late_count)
`endif
  );

  function automatic logic [79:0] mk(input logic [7:0] ch, input logic [7:0] op,
                                     input logic [31:0] t, input logic [31:0] pl);
    return {ch, op, t, pl};
  endfunction

  task automatic push(input logic [79:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: sample the pop strobe mid-cycle, then update FIFO and time base just after the edge.
  task automatic step();
    logic pop_now;
    @(negedge clk);
    pop_now = rd_en;
    if (pop_now && empty) begin
      tests_failed++;
      $display("FAIL rd_en_while_empty: rd_en=1 empty=1 at cycle %0d", cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now) begin
      pop_count++;
      pop_cycs.push_back(cyc);
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    end
    empty = (fifo_q.size() == 0);
    gclk  = gclk + 32'd1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!ctrl_valid && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [89:0] outs;
    rst = 1'b1; flush = 1'b0; ctrl_ready = 1'b0; gclk = 32'd0; empty = 1'b1; fifo_data = 80'd0;
    for (int i = 0; i < 3; i++) step();
    outs = {rd_en, ctrl_valid, ctrl_channel, ctrl_opcode, ctrl_payload, busy, drop_count, 8'd0};
    tests_run++;
    if (outs !== 90'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
`ifdef CMD_SCHED_LATE_COUNT_EN
    tests_run++;
    if (late_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_late_count: got %h expected 0", late_count);
    end
`endif
    rst = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b0 || ctrl_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: busy=%b valid=%b expected 0 0", busy, ctrl_valid);
    end
  endtask

  task automatic test_immediate();
    int n;
    int p0;
    ctrl_ready = 1'b1;
    p0 = pop_count;
    push(mk(8'h03, 8'hFF, 32'h0, 32'hCAFE0001));
    wait_valid(10, n);
    tests_run++;
    if (ctrl_valid !== 1'b1 || n != 3) begin
      tests_failed++;
      $display("FAIL imm_latency: valid=%b after %0d cycles, expected valid=1 after 3", ctrl_valid, n);
    end
    tests_run++;
    if (ctrl_channel !== 8'h03 || ctrl_opcode !== 8'hFF || ctrl_payload !== 32'hCAFE0001) begin
      tests_failed++;
      $display("FAIL imm_fields: got ch=%h op=%h pl=%h expected 03 ff cafe0001",
               ctrl_channel, ctrl_opcode, ctrl_payload);
    end
    step();
    tests_run++;
    if (ctrl_valid !== 1'b0 || busy !== 1'b0 || pop_count - p0 != 1) begin
      tests_failed++;
      $display("FAIL imm_done: valid=%b busy=%b pops=%0d expected 0 0 1", ctrl_valid, busy, pop_count - p0);
    end
  endtask

  task automatic test_timed();
    int n;
    ctrl_ready = 1'b1;
    gclk = 32'd0;
    push(mk(8'h04, 8'h01, 32'd100, 32'h12345678));
    wait_valid(200, n);
    tests_run++;
    if (ctrl_valid !== 1'b1 || gclk !== 32'd101) begin
      tests_failed++;
      $display("FAIL timed_first_valid: valid=%b at global_clock=%0d expected 1 at 101", ctrl_valid, gclk);
    end
    step();
    tests_run++;
    if (ctrl_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timed_deassert: valid=%b expected 0", ctrl_valid);
    end
`ifdef CMD_SCHED_LATE_COUNT_EN
    tests_run++;
    if (late_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL timed_not_late: late_count=%0d expected 0", late_count);
    end
`endif
  endtask

  task automatic test_wraparound();
    int n;
    ctrl_ready = 1'b1;
    gclk = 32'hFFFFFFF0;
    push(mk(8'h05, 8'h01, 32'h00000010, 32'hA5A5A5A5));
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (ctrl_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_no_early: valid=%b busy=%b expected 0 1", ctrl_valid, busy);
    end
    wait_valid(100, n);
    tests_run++;
    if (ctrl_valid !== 1'b1 || gclk !== 32'h00000011 || n != 30) begin
      tests_failed++;
      $display("FAIL wrap_dispatch: valid=%b gclk=%h wait=%0d expected 1 00000011 30", ctrl_valid, gclk, n);
    end
    step();
  endtask

  task automatic test_drop_nop();
    int n;
    int seen;
    ctrl_ready = 1'b1;
    seen = 0;
    push(mk(8'd64, 8'h01, 32'd0, 32'h11111111));
    push(mk(8'd5, 8'h00, 32'd0, 32'h22222222));
    push(mk(8'd7, 8'hFF, 32'd0, 32'h33333333));
    for (int i = 1; i <= 6; i++) begin
      step();
      if (ctrl_valid) seen++;
      if (i == 3) begin
        tests_run++;
        if (busy !== 1'b0 || drop_count !== 16'd1) begin
          tests_failed++;
          $display("FAIL drop_bad_channel: busy=%b drop_count=%0d expected 0 1", busy, drop_count);
        end
      end
    end
    tests_run++;
    if (seen != 0 || busy !== 1'b0 || drop_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL drop_nop_quiet: valids=%0d busy=%b drop_count=%0d expected 0 0 1", seen, busy, drop_count);
    end
    wait_valid(10, n);
    tests_run++;
    if (ctrl_valid !== 1'b1 || ctrl_channel !== 8'd7 || ctrl_payload !== 32'h33333333) begin
      tests_failed++;
      $display("FAIL after_drop_dispatch: valid=%b ch=%h pl=%h expected 1 07 33333333",
               ctrl_valid, ctrl_channel, ctrl_payload);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int p0;
    int q0;
    int got;
    logic [31:0] pl[2];
    ctrl_ready = 1'b1;
    flush = 1'b1;
    p0 = pop_count;
    push(mk(8'h01, 8'hFF, 32'd0, 32'hB0B0_0001));
    step();
    tests_run++;
    if (pop_count != p0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_no_pop: pops=%0d busy=%b expected 0 0", pop_count - p0, busy);
    end
    flush = 1'b0;
    push(mk(8'h02, 8'hFF, 32'd0, 32'hB0B0_0002));
    q0 = pop_cycs.size();
    got = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ctrl_valid) begin
        if (got < 2) pl[got] = ctrl_payload;
        got++;
      end
    end
    tests_run++;
    if (got != 2 || pl[0] !== 32'hB0B0_0001 || pl[1] !== 32'hB0B0_0002) begin
      tests_failed++;
      $display("FAIL b2b_dispatches: count=%0d pl0=%h pl1=%h expected 2 b0b00001 b0b00002", got, pl[0], pl[1]);
    end
    tests_run++;
    if (pop_cycs.size() - q0 != 2 || pop_cycs[q0 + 1] - pop_cycs[q0] != 4) begin
      tests_failed++;
      $display("FAIL b2b_spacing: pops=%0d spacing=%0d expected 2 4", pop_cycs.size() - q0,
               (pop_cycs.size() - q0 >= 2) ? pop_cycs[q0 + 1] - pop_cycs[q0] : -1);
    end
  endtask

  task automatic test_backpressure_flush();
    int n;
    int p0;
    int seen;
    logic stable;
    ctrl_ready = 1'b0;
    push(mk(8'h02, 8'hFF, 32'd0, 32'hDEADBEEF));
    wait_valid(10, n);
    stable = ctrl_valid;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (ctrl_valid !== 1'b1 || ctrl_channel !== 8'h02 || ctrl_opcode !== 8'hFF ||
          ctrl_payload !== 32'hDEADBEEF) stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_hold: stable=%b expected 1 (ch=%h pl=%h)", stable, ctrl_channel, ctrl_payload);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (ctrl_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_withdraw: valid=%b busy=%b expected 0 0", ctrl_valid, busy);
    end
    ctrl_ready = 1'b1;
    p0 = pop_count;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ctrl_valid) seen++;
    end
    tests_run++;
    if (seen != 0 || pop_count != p0) begin
      tests_failed++;
      $display("FAIL flush_no_redeliver: valids=%0d pops=%0d expected 0 0", seen, pop_count - p0);
    end
  endtask

  task automatic test_reset_mid_wait_late();
    int n;
    int seen;
    logic [81:0] outs;
    ctrl_ready = 1'b1;
    gclk = 32'd0;
    push(mk(8'h06, 8'h01, 32'd1000, 32'h66666666));
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (busy !== 1'b1 || ctrl_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_state: busy=%b valid=%b expected 1 0", busy, ctrl_valid);
    end
    rst = 1'b1;
    step();
    outs = {rd_en, ctrl_valid, ctrl_channel, ctrl_opcode, ctrl_payload, busy, drop_count};
    tests_run++;
    if (outs !== 82'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: got %h expected 0", outs);
    end
`ifdef CMD_SCHED_LATE_COUNT_EN
    tests_run++;
    if (late_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait_late: got %h expected 0", late_count);
    end
`endif
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ctrl_valid) seen++;
    end
    tests_run++;
    if (seen != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_discard: valids=%0d busy=%b expected 0 0", seen, busy);
    end
    gclk = 32'd50;
    push(mk(8'h09, 8'h01, 32'd5, 32'h99990005));
    wait_valid(10, n);
    tests_run++;
    if (ctrl_valid !== 1'b1 || n != 4 || ctrl_channel !== 8'h09 || ctrl_payload !== 32'h99990005) begin
      tests_failed++;
      $display("FAIL past_start_dispatch: valid=%b cycles=%0d ch=%h pl=%h expected 1 4 09 99990005",
               ctrl_valid, n, ctrl_channel, ctrl_payload);
    end
    step();
    tests_run++;
    if (ctrl_valid !== 1'b0 || drop_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL past_start_done: valid=%b drop_count=%0d expected 0 0", ctrl_valid, drop_count);
    end
`ifdef CMD_SCHED_LATE_COUNT_EN
    tests_run++;
    if (late_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL late_count: got %0d expected 1", late_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_timed();
    test_wraparound();
    test_drop_nop();
    test_back_to_back();
    test_backpressure_flush();
    test_reset_mid_wait_late();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
